cp_imem_boot: RTL and testbench

//  CP instruction memory with program-load front end; sits directly upstream of the CP fetch stage.

---
 rtl/cp_imem_boot.sv | 124 ++++++++++++
 tb/tb_cp_imem_boot.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp_imem_boot.sv
// rtl/cp_imem_boot.sv - CP instruction memory with program-load front end and core reset control
//
// Purpose: holds the CP program. A valid/ready word stream loads it while the CP core
// is held in reset. Fetch reads have a fixed 1-cycle latency.
//
// Ports:
//   iClk, iReset_n         clock; synchronous active-low reset
//   iLoad_Start            start a load (sampled only in HOLD/RUN)
//   iLoad_Base_Addr        first word address, captured on start
//   iLoad_Count            number of words (0..depth), captured on start
//   iLoad_Valid/Data       load word stream
//   oLoad_Ready            load word accepted when high with iLoad_Valid
//   oLoad_Busy             LOAD or DRAIN
//   oLoad_Done             one-cycle pulse when a load completes
//   oCore_Reset            active-high reset to the CP core
//   iIF_IMEM_Addr          fetch word address
//   oIMEM_IF_Instruction   fetched instruction, 1-cycle latency; NOP (0) unless running
module cp_imem_boot #(
  parameter int ADDR_WIDTH = 8,
  parameter int INS_WIDTH  = 32
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iLoad_Start,
  input  logic [ADDR_WIDTH-1:0] iLoad_Base_Addr,
  input  logic [ADDR_WIDTH:0]   iLoad_Count,
  input  logic                  iLoad_Valid,
  input  logic [INS_WIDTH-1:0]  iLoad_Data,
  output logic                  oLoad_Ready,
  output logic                  oLoad_Busy,
  output logic                  oLoad_Done,
  output logic                  oCore_Reset,
  input  logic [ADDR_WIDTH-1:0] iIF_IMEM_Addr,
  output logic [INS_WIDTH-1:0]  oIMEM_IF_Instruction
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  was_run_q, was_run_d;
  logic [INS_WIDTH-1:0]  data_q, data_d;
  logic                  mem_we;

  logic [INS_WIDTH-1:0]  mem_q [DEPTH];

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    remaining_d = remaining_q;
    mem_we      = 1'b0;
    unique case (state_q)
      S_HOLD, S_RUN: begin
        if (iLoad_Start) begin
          wptr_d      = iLoad_Base_Addr;
          remaining_d = iLoad_Count;
          // An empty load still passes through DRAIN so the core sees a clean reset release.
          state_d     = (iLoad_Count == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (iLoad_Valid) begin
          mem_we      = 1'b1;
          wptr_d      = wptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
          if (remaining_q == (ADDR_WIDTH + 1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
    // Instruction output is only released for reads issued while the core was running.
    was_run_d = (state_q == S_RUN);
    // Read sees the array before this cycle's write: read-old-data on collision.
    data_d    = mem_q[iIF_IMEM_Addr];
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q     <= S_HOLD;
      wptr_q      <= '0;
      remaining_q <= '0;
      was_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      remaining_q <= remaining_d;
      was_run_q   <= was_run_d;
    end
  end

  // Read data register is masked at the output, so it needs no reset.
  always_ff @(posedge iClk) begin
    data_q <= data_d;
  end

  // Array is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge iClk) begin
    if (mem_we && iReset_n) begin
      mem_q[wptr_q] <= iLoad_Data;
    end
  end

  assign oCore_Reset          = (state_q != S_RUN);
  assign oLoad_Ready          = (state_q == S_LOAD);
  assign oLoad_Busy           = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign oLoad_Done           = (state_q == S_DRAIN);
  assign oIMEM_IF_Instruction = was_run_q ? data_q : '0;

endmodule

// File: tb/tb_cp_imem_boot.sv
// tb/tb_cp_imem_boot.sv - self-checking bench for cp_imem_boot
module tb_cp_imem_boot;

  localparam int AW = 6;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_count = '0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;
  logic          core_reset;
  logic [AW-1:0] if_addr = '0;
  logic [IW-1:0] instr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp_imem_boot #(.ADDR_WIDTH(AW), .INS_WIDTH(IW)) dut (
    .iClk                 (clk),
    .iReset_n             (rst_n),
    .iLoad_Start          (load_start),
    .iLoad_Base_Addr      (load_base),
    .iLoad_Count          (load_count),
    .iLoad_Valid          (load_valid),
    .iLoad_Data           (load_data),
    .oLoad_Ready          (load_ready),
    .oLoad_Busy           (load_busy),
    .oLoad_Done           (load_done),
    .oCore_Reset          (core_reset),
    .iIF_IMEM_Addr        (if_addr),
    .oIMEM_IF_Instruction (instr)
  );

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic          valid;
    logic [IW-1:0] data;
    logic [AW-1:0] addr;
    logic          chk_en;
    logic          exp_ready;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_crst;
    logic [IW-1:0] exp_instr;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic r, input logic s, input logic [AW-1:0] b,
                              input logic [AW:0] c, input logic v, input logic [IW-1:0] d,
                              input logic [AW-1:0] a, input logic ce, input logic er,
                              input logic eb, input logic ed, input logic ec,
                              input logic [IW-1:0] ei);
    vec_t x;
    x.rst_n = r; x.start = s; x.base = b; x.cnt = c; x.valid = v; x.data = d; x.addr = a;
    x.chk_en = ce; x.exp_ready = er; x.exp_busy = eb; x.exp_done = ed; x.exp_crst = ec;
    x.exp_instr = ei;
    return x;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Loads n words seed, seed+1, ... at base; returns at the first negedge in RUN.
  task automatic do_load(input logic [AW-1:0] base, input int n, input logic [IW-1:0] seed);
    int t;
    @(negedge clk);
    load_start = 1'b1; load_base = base; load_count = (AW + 1)'(n); load_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = seed + IW'(i);
      t = 0;
      while (!load_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t == 20) chk1("load_ready_timeout", load_ready, 1'b1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    t = 0;
    while (!load_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk1("load_done_pulse", load_done, 1'b1);
    @(negedge clk);
    chk1("run_after_load", core_reset, 1'b0);
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [IW-1:0] exp);
    if_addr = a;
    @(negedge clk);
    chkw(name, instr, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, load 4 words at 0x10 with a 2-cycle gap after word 2, then read back
    tbl[0]  = mk(0, 0, 6'h00, 7'd0, 0, 32'h0,         6'h00, 0, 0, 0, 0, 1, 32'h0);
    tbl[1]  = mk(0, 0, 6'h00, 7'd0, 0, 32'h0,         6'h00, 1, 0, 0, 0, 1, 32'h0);
    tbl[2]  = mk(1, 1, 6'h10, 7'd4, 0, 32'h0,         6'h00, 1, 0, 0, 0, 1, 32'h0);
    tbl[3]  = mk(1, 0, 6'h00, 7'd0, 1, 32'h1111_0000, 6'h00, 1, 1, 1, 0, 1, 32'h0);
    tbl[4]  = mk(1, 1, 6'h00, 7'd7, 1, 32'h2222_0001, 6'h00, 1, 1, 1, 0, 1, 32'h0);
    tbl[5]  = mk(1, 0, 6'h00, 7'd0, 0, 32'hBAD0_0000, 6'h00, 1, 1, 1, 0, 1, 32'h0);
    tbl[6]  = mk(1, 0, 6'h00, 7'd0, 0, 32'hBAD0_0001, 6'h00, 1, 1, 1, 0, 1, 32'h0);
    tbl[7]  = mk(1, 0, 6'h00, 7'd0, 1, 32'h3333_0002, 6'h00, 1, 1, 1, 0, 1, 32'h0);
    tbl[8]  = mk(1, 0, 6'h00, 7'd0, 1, 32'h4444_0003, 6'h00, 1, 1, 1, 0, 1, 32'h0);
    tbl[9]  = mk(1, 1, 6'h00, 7'd0, 0, 32'h0,         6'h10, 1, 0, 1, 1, 1, 32'h0);
    tbl[10] = mk(1, 0, 6'h00, 7'd0, 0, 32'h0,         6'h10, 1, 0, 0, 0, 0, 32'h0);
    tbl[11] = mk(1, 0, 6'h00, 7'd0, 0, 32'h0,         6'h11, 1, 0, 0, 0, 0, 32'h1111_0000);
    tbl[12] = mk(1, 0, 6'h00, 7'd0, 0, 32'h0,         6'h12, 1, 0, 0, 0, 0, 32'h2222_0001);
    tbl[13] = mk(1, 0, 6'h00, 7'd0, 0, 32'h0,         6'h13, 1, 0, 0, 0, 0, 32'h3333_0002);
    tbl[14] = mk(1, 0, 6'h00, 7'd0, 0, 32'h0,         6'h00, 1, 0, 0, 0, 0, 32'h4444_0003);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tbl[i].chk_en) begin
        chk1($sformatf("vec%0d_ready", i), load_ready, tbl[i].exp_ready);
        chk1($sformatf("vec%0d_busy", i), load_busy, tbl[i].exp_busy);
        chk1($sformatf("vec%0d_done", i), load_done, tbl[i].exp_done);
        chk1($sformatf("vec%0d_core_reset", i), core_reset, tbl[i].exp_crst);
        chkw($sformatf("vec%0d_instr", i), instr, tbl[i].exp_instr);
      end
      rst_n      = tbl[i].rst_n;
      load_start = tbl[i].start;
      load_base  = tbl[i].base;
      load_count = tbl[i].cnt;
      load_valid = tbl[i].valid;
      load_data  = tbl[i].data;
      if_addr    = tbl[i].addr;
    end

    // count == 0: Done the cycle after start, RUN the cycle after, Ready never high
    @(negedge clk);
    load_start = 1'b1; load_base = 6'h00; load_count = 7'd0;
    @(negedge clk);
    load_start = 1'b0;
    chk1("zero_cnt_done", load_done, 1'b1);
    chk1("zero_cnt_ready_drain", load_ready, 1'b0);
    chk1("zero_cnt_crst_drain", core_reset, 1'b1);
    @(negedge clk);
    chk1("zero_cnt_done_clear", load_done, 1'b0);
    chk1("zero_cnt_ready_run", load_ready, 1'b0);
    chk1("zero_cnt_run", core_reset, 1'b0);

    // write pointer wraps from depth-1 to 0
    do_load(6'd62, 4, 32'hA000_0000);
    read_chk("wrap_62", 6'd62, 32'hA000_0000);
    read_chk("wrap_63", 6'd63, 32'hA000_0001);
    read_chk("wrap_00", 6'd0,  32'hA000_0002);
    read_chk("wrap_01", 6'd1,  32'hA000_0003);

    // reset after 2 of 5 words: first two replaced, other three keep previous contents
    do_load(6'h20, 5, 32'hC000_0000);
    @(negedge clk);
    load_start = 1'b1; load_base = 6'h20; load_count = 7'd5;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'hB000_0000;
    @(negedge clk);
    load_data = 32'hB000_0001;
    @(negedge clk);
    load_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("midrst_crst", core_reset, 1'b1);
    chk1("midrst_ready", load_ready, 1'b0);
    chk1("midrst_busy", load_busy, 1'b0);
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("hold_ready", load_ready, 1'b0);
    load_valid = 1'b0; load_start = 1'b1; load_count = 7'd0;
    @(negedge clk);
    load_start = 1'b0;
    @(negedge clk);
    chk1("midrst_reload_run", core_reset, 1'b0);
    read_chk("midrst_w0", 6'h20, 32'hB000_0000);
    read_chk("midrst_w1", 6'h21, 32'hB000_0001);
    read_chk("midrst_w2", 6'h22, 32'hC000_0002);
    read_chk("midrst_w3", 6'h23, 32'hC000_0003);
    read_chk("midrst_w4", 6'h24, 32'hC000_0004);

    // reload from RUN: core reset next cycle, instruction forced to NOP the cycle after
    if_addr = 6'h20; load_start = 1'b1; load_base = 6'h30; load_count = 7'd1;
    @(negedge clk);
    load_start = 1'b0; if_addr = 6'h21;
    chk1("reload_crst", core_reset, 1'b1);
    chkw("reload_last_instr", instr, 32'hB000_0000);
    @(negedge clk);
    chkw("reload_nop", instr, 32'h0);
    load_valid = 1'b1; load_data = 32'h5555_AAAA;
    @(negedge clk);
    load_valid = 1'b0;
    chk1("reload_done", load_done, 1'b1);
    @(negedge clk);
    read_chk("reload_word", 6'h30, 32'h5555_AAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
